// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: 32-entry single-precision FP register file with busy-bit scoreboard.
// Two combinational read ports feed the FP adder operands. The write port takes
// the adder result at writeback and bypasses it to same-cycle readers. The
// scoreboard stalls issue while a source or destination has a write in flight.
module fp_regfile_sb #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int FTZ      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_uses_rs2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  // Flush-to-zero: a zero exponent field (zero or denormal) keeps only the sign.
  function automatic logic [DATA_W-1:0] ftz_value(input logic [DATA_W-1:0] v);
    if ((FTZ != 0) && (v[DATA_W-2 -: 8] == 8'd0))
      return {v[DATA_W-1], {(DATA_W-1){1'b0}}};
    return v;
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   wr_value;
  logic [NUM_REGS-1:0] wr_onehot;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                accept;

  // Value actually committed, shared by the storage write and the bypass path.
  always_comb begin
    wr_value = ftz_value(wr_data);
  end

  // Read ports: a write landing this cycle is forwarded ahead of the array.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (we && (wr_addr == rs1_addr)) rs1_data = wr_value;
    if (we && (wr_addr == rs2_addr)) rs2_data = wr_value;
  end

  // A register completing writeback this cycle counts as ready for issue.
  always_comb begin
    wr_onehot = '0;
    if (we) wr_onehot[wr_addr] = 1'b1;
    eff_busy = busy_vec & ~wr_onehot;
  end

  // Issue hazard check: RAW on either used source, WAW on the destination.
  always_comb begin
    stall  = issue_valid &&
             (eff_busy[rs1_addr] ||
              (issue_uses_rs2 && eff_busy[rs2_addr]) ||
              eff_busy[issue_rd]);
    accept = issue_valid && !stall;
  end

  // Next scoreboard state: writeback clears first, so an accepted issue to
  // the same register leaves its bit set.
  always_comb begin
    busy_nxt = busy_vec;
    if (we)     busy_nxt[wr_addr]  = 1'b0;
    if (accept) busy_nxt[issue_rd] = 1'b1;
  end

  // Register array storage; reset clears every entry and overrides writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_addr] <= wr_value;
    end
  end

  // Scoreboard register; reset discards every in-flight write.
  always_ff @(posedge clk) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb_fp_regfile_sb: directed vector table for the corner cases followed by
// randomized traffic checked against an array-based reference model.
module tb_fp_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        we, issue_valid, issue_uses_rs2, stall;
  logic [31:0] busy_vec;

  int n_vec = 0;
  int n_bad = 0;

  fp_regfile_sb #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FTZ(1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_uses_rs2(issue_uses_rs2),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        iv;
    logic [4:0]  rd;
    logic        u2;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic        e_stall;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[17];

  // Reference model state
  logic [31:0] mreg [32];
  logic        mbusy[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_store(input logic [31:0] v);
    if (v[30:23] == 8'd0) return {v[31], 31'b0};
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (we && wr_addr == a) return m_store(wr_data);
    return mreg[a];
  endfunction

  function automatic logic m_ready(input logic [4:0] a);
    return !mbusy[a] || (we && wr_addr == a);
  endfunction

  function automatic logic m_stall();
    if (!issue_valid) return 1'b0;
    return !m_ready(rs1_addr) || (issue_uses_rs2 && !m_ready(rs2_addr)) || !m_ready(issue_rd);
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int k = 0; k < 32; k++) w[k] = mbusy[k];
    return w;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin
      mreg[k]  = 32'h0;
      mbusy[k] = 1'b0;
    end
  endtask

  task automatic set_row(input vec_t v);
    rst = v.rst; we = v.we; wr_addr = v.wa; wr_data = v.wd;
    rs1_addr = v.r1; rs2_addr = v.r2;
    issue_valid = v.iv; issue_rd = v.rd; issue_uses_rs2 = v.u2;
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2, input logic iv,
                              input logic [4:0] rd, input logic u2, input logic [31:0] e1,
                              input logic [31:0] e2, input logic es, input logic [31:0] eb);
    vec_t v;
    v.rst = r; v.we = w; v.wa = wa; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.iv = iv; v.rd = rd; v.u2 = u2; v.e_r1 = e1; v.e_r2 = e2; v.e_stall = es; v.e_busy = eb;
    return v;
  endfunction

  logic        prev_stall;
  logic        exp_s;
  logic [31:0] exp1, exp2;

  initial begin
    //            rst we wa  wd            r1  r2  iv rd  u2  e_r1          e_r2   st  busy
    tbl[0]  = mk(1, 1, 3, 32'h3FC0_0000, 3, 4, 1, 4, 1, 32'h3FC0_0000, 32'h0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,         3, 4, 0, 0, 0, 32'h0,         32'h0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 3, 32'h3FC0_0000, 3, 0, 0, 0, 0, 32'h3FC0_0000, 32'h0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h0,         3, 0, 0, 0, 0, 32'h3FC0_0000, 32'h0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,         0, 0, 1, 5, 1, 32'h0,         32'h0, 0, 32'h20);
    tbl[5]  = mk(0, 0, 0, 32'h0,         1, 5, 1, 6, 1, 32'h0,         32'h0, 1, 32'h20);
    tbl[6]  = mk(0, 0, 0, 32'h0,         1, 5, 1, 6, 0, 32'h0,         32'h0, 0, 32'h60);
    tbl[7]  = mk(0, 1, 5, 32'hC000_0000, 5, 0, 1, 8, 1, 32'hC000_0000, 32'h0, 0, 32'h140);
    tbl[8]  = mk(0, 0, 0, 32'h0,         0, 0, 1, 7, 0, 32'h0,         32'h0, 0, 32'h1C0);
    tbl[9]  = mk(0, 1, 7, 32'h4040_0000, 7, 0, 1, 7, 0, 32'h4040_0000, 32'h0, 0, 32'h1C0);
    tbl[10] = mk(0, 0, 0, 32'h0,         7, 0, 1, 6, 0, 32'h4040_0000, 32'h0, 1, 32'h1C0);
    tbl[11] = mk(0, 1, 9, 32'h8000_1234, 9, 3, 0, 0, 0, 32'h8000_0000, 32'h3FC0_0000, 0, 32'h1C0);
    tbl[12] = mk(0, 0, 0, 32'h0,         9, 5, 0, 0, 0, 32'h8000_0000, 32'hC000_0000, 0, 32'h1C0);
    tbl[13] = mk(0, 0, 0, 32'h0,         0, 0, 1, 2, 1, 32'h0,         32'h0, 0, 32'h1C4);
    tbl[14] = mk(0, 0, 0, 32'h0,         0, 0, 1, 9, 1, 32'h0,         32'h0, 0, 32'h3C4);
    tbl[15] = mk(1, 0, 0, 32'h0,         9, 2, 0, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0);
    tbl[16] = mk(0, 0, 0, 32'h0,         9, 3, 0, 0, 0, 32'h0,         32'h0, 0, 32'h0);

    set_row(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      set_row(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d_rs1", i), rs1_data, tbl[i].e_r1);
      chk($sformatf("tbl%0d_rs2", i), rs2_data, tbl[i].e_r2);
      chk($sformatf("tbl%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_busy", i), busy_vec, tbl[i].e_busy);
    end

    // Randomized traffic against the reference model (state is all-zero here)
    m_reset();
    prev_stall = 1'b0;
    set_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 2) == 0);
      wr_addr = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       wr_data = {1'($urandom), 8'h00, 23'($urandom)};
        default: wr_data = $urandom;
      endcase
      if (!prev_stall) begin
        issue_valid    = ($urandom_range(0, 1) == 1);
        issue_rd       = 5'($urandom_range(0, 7));
        issue_uses_rs2 = 1'($urandom);
        rs1_addr       = 5'($urandom_range(0, 7));
        rs2_addr       = 5'($urandom_range(0, 7));
      end
      @(negedge clk);
      exp1  = m_read(rs1_addr);
      exp2  = m_read(rs2_addr);
      exp_s = m_stall();
      chk("rnd_rs1", rs1_data, exp1);
      chk("rnd_rs2", rs2_data, exp2);
      chk("rnd_stall", {31'b0, stall}, {31'b0, exp_s});
      @(posedge clk);
      if (rst) begin
        m_reset();
      end else begin
        if (we) begin
          mreg[wr_addr]  = m_store(wr_data);
          mbusy[wr_addr] = 1'b0;
        end
        if (issue_valid && !exp_s) mbusy[issue_rd] = 1'b1;
      end
      prev_stall = exp_s && !rst;
      #1;
      chk("rnd_busy", busy_vec, m_busy_word());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
